// File: rtl/packed_cmd_arbiter_pkg.sv
// ============================================================================
//  Module      : packed_cmd_arbiter_pkg
//  Description : Packed-command layout, arbiter FSM states and error data.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package packed_cmd_arbiter_pkg;

    typedef struct packed {
        logic        write_not_read;
        logic [22:0] addr;
        logic [7:0]  data;
    } packed_cmd_s;

    localparam int c_cmd_width = $bits(packed_cmd_s);

    typedef enum logic [1:0] {
        e_idle      = 2'd0,
        e_wait_resp = 2'd1,
        e_err_resp  = 2'd2
    } arb_state_e;

    // Returned to the owning requester in place of real data after a timeout
    localparam logic [31:0] c_timeout_data = 32'hDEAD_BEEF;

    function automatic logic cmd_is_write(input logic [c_cmd_width-1:0] cmd);
        return cmd[c_cmd_width-1];
    endfunction

endpackage

`default_nettype wire

// File: rtl/bsg_arb_round_robin.sv
// ============================================================================
//  Module      : bsg_arb_round_robin
//  Description : Round-robin arbiter; pointer advances past the winner on yumi.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bsg_arb_round_robin #(
    parameter int width_p = 2
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic [width_p-1:0]                     reqs_i,
    output logic [width_p-1:0]                     grants_o,
    output logic [(width_p>1?$clog2(width_p):1)-1:0] tag_o,
    output logic                                   v_o,
    input  logic                                   yumi_i
);

    localparam int c_tag_w = (width_p > 1) ? $clog2(width_p) : 1;

    logic [c_tag_w-1:0] r_ptr;
    logic [c_tag_w-1:0] w_tag;
    logic               w_found;

    function automatic logic [c_tag_w-1:0] wrap_idx(input logic [c_tag_w-1:0] base,
                                                    input int                 offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= width_p) begin
            sum = sum - width_p;
        end
        return c_tag_w'(sum);
    endfunction

    // Search starts at the pointer so the last winner has lowest priority
    always_comb begin
        w_found = 1'b0;
        w_tag   = '0;
        for (int i = 0; i < width_p; i++) begin
            if (!w_found && reqs_i[wrap_idx(r_ptr, i)]) begin
                w_found = 1'b1;
                w_tag   = wrap_idx(r_ptr, i);
            end
        end
    end

    assign tag_o    = w_tag;
    assign v_o      = w_found;
    assign grants_o = w_found ? (width_p'(1) << w_tag) : '0;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_ptr <= '0;
        end else if (yumi_i) begin
            r_ptr <= (w_tag == c_tag_w'(width_p - 1)) ? '0 : w_tag + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/packed_cmd_arbiter.sv
// ============================================================================
//  Module      : packed_cmd_arbiter
//  Description : Arbitrates packed commands onto one channel and routes read
//                responses back to the issuing requester, with timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module packed_cmd_arbiter
    import packed_cmd_arbiter_pkg::*;
#(
    parameter int num_req_p = 2,
    parameter int timeout_p = 1024
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [num_req_p-1:0][31:0]  req_data_i,
    input  logic [num_req_p-1:0]        req_v_i,
    output logic [num_req_p-1:0]        req_ready_o,
    output logic [31:0]                 resp_data_o,
    output logic [num_req_p-1:0]        resp_v_o,
    input  logic [num_req_p-1:0]        resp_ready_i,
    output logic [31:0]                 data_o,
    output logic                        v_o,
    input  logic                        ready_i,
    input  logic [31:0]                 data_i,
    input  logic                        v_i,
    output logic                        ready_o,
    output logic                        timeout_o,
    output logic [7:0]                  drop_count_o
);

    localparam int c_owner_w = $clog2(num_req_p);
    localparam int c_timer_w = $clog2(timeout_p);

    arb_state_e              r_state;
    arb_state_e              w_state_n;
    logic [c_owner_w-1:0]    r_owner;
    logic [c_owner_w-1:0]    w_owner_n;
    logic [c_timer_w-1:0]    r_timer;
    logic [c_timer_w-1:0]    w_timer_n;
    logic                    r_timeout;
    logic                    w_timeout_set;
    logic [7:0]              r_drop_count;
    logic                    w_drop;

    logic [num_req_p-1:0]    w_grants;
    logic [c_owner_w-1:0]    w_grant;
    logic                    w_arb_v;
    logic                    w_cmd_hs;

    assign w_cmd_hs = (r_state == e_idle) & ~reset_i & w_arb_v & ready_i;

    bsg_arb_round_robin #(
        .width_p (num_req_p)
    ) u_rr (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .reqs_i   (req_v_i),
        .grants_o (w_grants),
        .tag_o    (w_grant),
        .v_o      (w_arb_v),
        .yumi_i   (w_cmd_hs)
    );

    always_comb begin
        w_state_n     = r_state;
        w_owner_n     = r_owner;
        w_timer_n     = r_timer;
        w_timeout_set = 1'b0;
        w_drop        = 1'b0;
        v_o           = 1'b0;
        req_ready_o   = '0;
        data_o        = req_data_i[w_grant];
        resp_v_o      = '0;
        resp_data_o   = '0;
        ready_o       = 1'b0;

        case (r_state)
            e_idle: begin
                v_o         = w_arb_v & ~reset_i;
                req_ready_o = reset_i ? '0 : (w_grants & {num_req_p{ready_i}});
                // Nothing is outstanding, so any response here is stale
                ready_o     = 1'b1;
                w_drop      = v_i;
                if (w_cmd_hs && !cmd_is_write(req_data_i[w_grant])) begin
                    w_owner_n = w_grant;
                    w_timer_n = '0;
                    w_state_n = e_wait_resp;
                end
            end
            e_wait_resp: begin
                resp_v_o[r_owner] = v_i & ~reset_i;
                resp_data_o       = data_i;
                ready_o           = resp_ready_i[r_owner];
                // A response in the expiry cycle wins over the timeout
                if (v_i && resp_ready_i[r_owner]) begin
                    w_state_n = e_idle;
                end else if (r_timer == c_timer_w'(timeout_p - 1)) begin
                    w_state_n     = e_err_resp;
                    w_timeout_set = 1'b1;
                end else begin
                    w_timer_n = r_timer + 1'b1;
                end
            end
            e_err_resp: begin
                resp_v_o[r_owner] = ~reset_i;
                resp_data_o       = c_timeout_data;
                if (resp_ready_i[r_owner]) begin
                    w_state_n = e_idle;
                end
            end
            default: begin
                w_state_n = e_idle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state      <= e_idle;
            r_owner      <= '0;
            r_timer      <= '0;
            r_timeout    <= 1'b0;
            r_drop_count <= 8'd0;
        end else begin
            r_state <= w_state_n;
            r_owner <= w_owner_n;
            r_timer <= w_timer_n;
            if (w_timeout_set) begin
                r_timeout <= 1'b1;
            end
            if (w_drop && (r_drop_count != 8'hFF)) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

    assign timeout_o    = r_timeout;
    assign drop_count_o = r_drop_count;

endmodule

`default_nettype wire

// File: doc/packed_cmd_arbiter.md
PACKED_CMD_ARBITER -- requirements
Module: packed_cmd_arbiter

Interface
REQ-001 SHALL have parameter num_req_p, default 2, meaning number of packed-command requesters (2..4).
REQ-002 SHALL have parameter timeout_p, default 1024, meaning max cycles to wait for a read response (power of two, >=4).
REQ-003 SHALL have port clk_i  input  1  clock; one clock domain.
REQ-004 SHALL have port reset_i  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port req_data_i  input  num_req_p x 32  packed commands {write_not_read, addr[22:0], data[7:0]}.
REQ-006 SHALL have port req_v_i / req_ready_o  input / output  num_req_p each  per-requester valid/ready.
REQ-007 SHALL have port resp_data_o  output  32  read response data, shared by all requesters.
REQ-008 SHALL have port resp_v_o / resp_ready_i  output / input  num_req_p each  per-requester response valid/ready.
REQ-009 SHALL have port data_o / v_o / ready_i  output 32 / output 1 / input 1  downstream command channel.
REQ-010 SHALL have port data_i / v_i / ready_o  input 32 / input 1 / output 1  downstream read-response channel.
REQ-011 SHALL have port timeout_o  output  1  sticky flag, set on any read timeout.
REQ-012 SHALL have port drop_count_o  output  8  saturating count of discarded stale responses.

Function
REQ-013 SHALL have states e_idle, e_wait_resp, e_err_resp.
REQ-014 In e_idle, SHALL grant one valid requester round-robin, starting at the index after the last granted one (index 0 first after reset).
REQ-015 SHALL make grant combinational: data_o = req_data_i[grant], v_o = |req_v_i, req_ready_o[grant] = ready_i; all other req_ready_o = 0.
REQ-016 SHALL advance the round-robin pointer only on a downstream handshake (v_o & ready_i).
REQ-017 Write (bit31=1) handshake SHALL stay in e_idle; back-to-back writes SHALL issue one per cycle.
REQ-018 Read (bit31=0) handshake SHALL record owner = grant, clear timer, go to e_wait_resp.
REQ-019 In e_wait_resp and e_err_resp, v_o and all req_ready_o SHALL be 0.
REQ-020 In e_wait_resp, resp_v_o[owner] = v_i, resp_data_o = data_i, ready_o = resp_ready_i[owner]; on v_i & ready_o, go to e_idle.
REQ-021 Timer SHALL increment each e_wait_resp cycle without response handshake; on reaching timeout_p-1, go to e_err_resp, set timeout_o.
REQ-022 In e_err_resp, resp_v_o[owner] = 1, resp_data_o = 32'hDEAD_BEEF, ready_o = 0; on resp_ready_i[owner], go to e_idle.
REQ-023 In e_idle, ready_o SHALL be 1; any v_i there is a stale response, discarded, and increments drop_count_o (saturates at 255).
REQ-024 A response handshake and timer expiry in the same cycle SHALL resolve as a response (no timeout).
REQ-025 resp_v_o of non-owner requesters SHALL always be 0.

Reset
REQ-026 On reset_i: state e_idle, rr pointer 0, owner 0, timer 0, timeout_o 0, drop_count_o 0.
REQ-027 Reset mid-read SHALL abandon the transaction; a response arriving after reset is discarded per REQ-023.
REQ-028 During reset, v_o, req_ready_o and resp_v_o SHALL be 0.

Structure
REQ-029 State enum and timeout data constant (32'hDEAD_BEEF) SHALL live in the shared bp_me-side package with the packed-command definitions.
REQ-030 Grant logic SHALL use one sub-module, bsg_arb_round_robin, with its yumi driven by the downstream handshake.

Verification
REQ-031 Req0 and req1 both valid writes, ready_i=1 -> issue order 0,1,0,1 one per cycle, no resp_v_o.
REQ-032 Req1 read 0x0012_3400, response 0x0000_00A5 after 5 cycles -> resp_v_o[1]=1 with 0xA5; req0 stalled until handshake.
REQ-033 Read issued, no v_i for timeout_p cycles -> resp 0xDEAD_BEEF to owner, timeout_o=1; a late v_i in e_idle -> drop_count_o=1.
REQ-034 Response valid while resp_ready_i[owner]=0 for 3 cycles -> ready_o=0, data held, single delivery.
REQ-035 reset_i asserted in e_wait_resp -> next cycle e_idle, all outputs at reset values, new read from req0 proceeds normally.
REQ-036 ready_i=0 with req0 valid for 10 cycles -> req_ready_o=0, pointer unchanged, grant unchanged when req1 becomes valid.
